// File: rtl/lsu_dmem_master.sv
// Load/store unit for the MEM stage. It turns byte, halfword and word requests into
// word-wide accesses to a word-addressed memory that reads combinationally and writes
// on the clock edge. Sub-word stores use a read-modify-write sequence. Misaligned or
// reserved-size requests are answered with an error and never reach the memory.
module lsu_dmem_master #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             busy,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StResp
  } state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] merge_q, merge_d;

  logic             req_err;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] merge_word;
  logic             sign_b;
  logic             sign_h;

  // Classify the incoming request as misaligned or reserved-size.
  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      SizeByte: req_err = 1'b0;
      SizeHalf: req_err = req_addr[0];
      SizeWord: req_err = (req_addr[1:0] != 2'b00);
      SizeRsvd: req_err = 1'b1;
      default:  req_err = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, from latched request.
  always_comb begin
    sh_amt  = {addr_q[1:0], 3'b000};
    shifted = mem_rdata >> sh_amt;
    sign_b  = ~unsigned_q & shifted[7];
    sign_h  = ~unsigned_q & shifted[15];
    unique case (size_q)
      SizeByte: load_ext = {{(WIDTH-8){sign_b}}, shifted[7:0]};
      SizeHalf: load_ext = {{(WIDTH-16){sign_h}}, shifted[15:0]};
      default:  load_ext = mem_rdata;
    endcase
    if (size_q == SizeByte) begin
      lane_mask = {{(WIDTH-8){1'b0}}, 8'hFF} << sh_amt;
    end else begin
      lane_mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << sh_amt;
    end
    merge_word = (mem_rdata & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);
  end

  // Next-state logic and capture of request, load result and merge word.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          err_d      = req_err;
          rdata_d    = '0;
          merge_d    = '0;
          if (req_err) begin
            state_d = StResp;
          end else if (!req_write) begin
            state_d = StLoad;
          end else if (req_size == SizeWord) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rdata_d = load_ext;
        state_d = StResp;
      end
      StRmwRd: begin
        merge_d = merge_word;
        state_d = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      merge_q    <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      merge_q    <= merge_d;
    end
  end

  // Memory port and handshake outputs, decoded from registered state only.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StResp);
    rsp_err   = (state_q == StResp) & err_q;
    rsp_rdata = (state_q == StResp) ? rdata_q : '0;
    mem_we    = (state_q == StWrite);
    mem_addr  = '0;
    mem_wdata = '0;
    if ((state_q == StLoad) || (state_q == StRmwRd) || (state_q == StWrite)) begin
      mem_addr = {addr_q[WIDTH-1:2], 2'b00};
    end
    if (state_q == StWrite) begin
      // write_q is always set here; word stores bypass the merge path.
      mem_wdata = (write_q && (size_q == SizeWord)) ? wdata_q : merge_q;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a behavioural memory, a reference memory
// image and scoreboards for responses and memory writes.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_master #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural data memory: combinational read, clocked write, plus a preload port.
  logic [31:0] mem [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  logic [31:0] ref_mem [0:63];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] due;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_r;
  wr_t  mon_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every response and every memory write must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_r.err});
          check("rsp_rdata", rsp_rdata, mon_r.rdata);
          check("rsp_latency", cyc, mon_r.due);
        end
      end
      if (mem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_addr, mon_w.addr);
          check("wr_data", mem_wdata, mon_w.data);
        end
      end
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_idx  = addr[7:2];
    poke_data = data;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    ref_mem[addr[7:2]] = data;
  endtask

  // Issue one request, push its expected outcome, return the accept cycle.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic hold,
                        output int acc);
    int          n;
    logic        err;
    logic [31:0] rd;
    logic [31:0] word;
    logic [7:0]  b [4];
    logic [15:0] h;
    logic [1:0]  lo;
    logic [1:0]  hi;
    int          lat;
    rsp_t        r;
    wr_t         w;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    acc = cyc;
    err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    word = ref_mem[addr[7:2]];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    lo = {addr[1], 1'b0};
    hi = {addr[1], 1'b1};
    rd = 32'h0;
    if (!err && !wr) begin
      if (sz == 2'b00) rd = uns ? {24'h0, b[addr[1:0]]} : {{24{b[addr[1:0]][7]}}, b[addr[1:0]]};
      else if (sz == 2'b01) begin
        h  = {b[hi], b[lo]};
        rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end else rd = word;
    end
    if (!err && wr) begin
      if (sz == 2'b10) word = wd;
      else begin
        if (sz == 2'b00) b[addr[1:0]] = wd[7:0];
        else begin
          b[lo] = wd[7:0];
          b[hi] = wd[15:8];
        end
        word = {b[3], b[2], b[1], b[0]};
      end
      ref_mem[addr[7:2]] = word;
      w.addr = {addr[31:2], 2'b00};
      w.data = word;
      wr_q.push_back(w);
    end
    lat = err ? 1 : (!wr ? 2 : (sz == 2'b10 ? 2 : 3));
    r.err   = err;
    r.rdata = rd;
    r.due   = acc + lat - 1;
    rsp_q.push_back(r);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("ready_after_accept", {31'b0, req_ready}, 32'd0);
    if (!hold) begin
      // Scramble inputs to show only latched copies matter.
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("rsp_timeout", rsp_q.size(), 32'd0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int a0, a1, a2, a3;

  initial begin
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    // Reset values while held in reset.
    #12;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 64; i++) poke(i * 4, 32'h0);

    // Word store then load back.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, a0);
    wait_done();

    // Byte read-modify-write, then read the whole word.
    poke(32'h20, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFBEEF, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, a0);
    wait_done();

    // Sign and zero extension.
    poke(32'h30, 32'h80F07F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0, a0);
    wait_done();

    // Errors: misaligned halfword, misaligned word, reserved size.
    do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 1'b0, a0);
    wait_done();
    do_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h55555555, 1'b0, a0);
    wait_done();
    do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h66666666, 1'b0, a0);
    wait_done();

    // Reset pulsed while a halfword store sits in its read phase.
    poke(32'h50, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b01;
    req_addr  = 32'h52;
    req_wdata = 32'h00009999;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_busy_rmw", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", {31'b0, mem_we}, 32'd0);
    check("abort_busy_rst", {31'b0, busy}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_mem_word", mem[20], 32'h55667788);
    check("abort_ready", {31'b0, req_ready}, 32'd1);

    // Continuous req_valid: accept spacing of 3, 3, 4 cycles.
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, a0);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, a1);
    do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h00000077, 1'b1, a2);
    do_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 1'b0, a3);
    wait_done();
    check("burst_gap_sw", a1 - a0, 32'd3);
    check("burst_gap_lw", a2 - a1, 32'd3);
    check("burst_gap_sb", a3 - a2, 32'd4);
    check("burst_mem_word", mem[16], 32'hCAFE770D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
